alu_issue_32: RTL
=================

# alu_issue_32

Registered issue stage in front of `alu_32` in the MIPS datapath. It accepts a fetched instruction word with its register operand values over a valid/ready handshake, and decodes opcode/funct into the ALU's 4-bit control code, shift amount and B operand. It presents these to the ALU side over a second valid/ready handshake, together with writeback and trap side-band bits. Backpressure from the execute side is absorbed by an output skid buffer.

## Interface
Parameters:
- none (datapath fixed at 32 bits).

Ports:
- `clk  in  1` — single clock; all state changes on rising edge.
- `rst_n  in  1` — reset, asynchronous, active-low.
- `flush  in  1` — synchronous clear of all buffered entries.
- `in_valid  in  1` — upstream instruction/operands valid.
- `in_ready  out  1` — stage can accept this cycle.
- `in_instr  in  32` — MIPS instruction word.
- `in_rs_val  in  32` — value of register rs.
- `in_rt_val  in  32` — value of register rt.
- `out_valid  out  1` — issued operation valid.
- `out_ready  in  1` — execute side accepts this cycle.
- `out_a  out  32` — ALU operand A (rs value).
- `out_b  out  32` — ALU operand B (rt value or extended immediate).
- `out_control  out  4` — ALU control code.
- `out_shamt  out  5` — shift amount, `instr[10:6]`.
- `out_wr_en  out  1` — result is written back.
- `out_wr_reg  out  5` — destination register.
- `out_ovf_trap  out  1` — signed overflow must trap.
- `out_illegal  out  1` — instruction not decodable.

## Operation
- ALU control codes: sll 0000, srl 0010, add 1000, slt 1001, sub 1010, sltu 1011, and 1100, or 1101, xor 1110.
- R-type decode (opcode 0x00, `wr_reg`=rd, `b`=rt):
  - funct 0x00 → sll.
  - funct 0x02 → srl.
  - funct 0x20 add / 0x21 addu → add.
  - funct 0x22 sub / 0x23 subu → sub.
  - funct 0x24 → and; 0x25 → or; 0x26 → xor.
  - funct 0x2A → slt; 0x2B → sltu.
- I-type decode (`wr_reg`=rt, except sw/beq/bne, which have `wr_en`=0):
  - 0x08 addi, 0x09 addiu, 0x23 lw, 0x2B sw → add, sign-extended immediate.
  - 0x0A slti → slt, sign-extended.
  - 0x0B sltiu → sltu, sign-extended.
  - 0x0C andi, 0x0D ori, 0x0E xori → and/or/xor, zero-extended.
  - 0x04 beq, 0x05 bne → sub, `b`=rt value.
- `ovf_trap`=1 only for add, sub and addi.
- Any other opcode/funct:
  - `illegal`=1, `control`=1000, `wr_en`=0, `ovf_trap`=0.
  - Operands pass through as for R-type.
- Writes to register 0 keep `wr_en`=1; suppression is the register file's job.
- Storage:
  - Main output register (M).
  - Skid register (S), present when the configuration macro is enabled.
  - Entries issue in acceptance order; none is dropped or duplicated.
- States: EMPTY (M invalid), ONE (M valid, S empty), FULL (M and S valid).
  - EMPTY + accept → ONE.
  - ONE + accept + out_ready → ONE (M replaced).
  - ONE + accept + !out_ready → FULL (new entry into S).
  - ONE + out_ready + no accept → EMPTY.
  - FULL + out_ready → ONE (S moves to M).
- Reset and flush:
  - `flush` → EMPTY, overriding any simultaneous accept or issue.
  - Async reset mid-operation discards all entries immediately.

## Timing
- Reset values:
  - `out_valid`=0, `in_ready`=1.
  - All data and side-band outputs 0.
- Latency: one cycle from accept (`in_valid & in_ready`) to `out_valid`.
- Throughput: one operation per cycle while `out_ready`=1.
- `in_ready` is registered and equals "S empty". It does not depend combinationally on `out_ready`.
- Handshake rules:
  - Outputs are stable while `out_valid & !out_ready`.
  - Upstream must hold its inputs while `in_valid & !in_ready`.
- The cycle after flush: `out_valid`=0, `in_ready`=1.

## Configuration
- `ALU_ISSUE_SKID_EN` defined:
  - S present.
  - `in_ready` registered as described above.
- Not defined:
  - No S; the FULL state does not exist.
  - `in_ready = !out_valid | out_ready` (combinational).
  - Same latency and throughput.

## Test plan
- Reset: assert `rst_n`=0 mid-transfer → `out_valid`=0, `in_ready`=1, all outputs 0 asynchronously.
- Decode sweep: one instruction per supported encoding with `out_ready`=1 → correct control/b/wr fields one cycle later. Example: addiu rt=5, imm=0xFFFF → control 1000, `b`=0xFFFFFFFF, `wr_reg`=5, `ovf_trap`=0.
- Zero-extend: ori imm=0x8001 → `b`=0x00008001, control 1101.
- Illegal: opcode 0x3F → `illegal`=1, control 1000, `wr_en`=0.
- Backpressure: hold `out_ready`=0 while issuing add then sub.
  - Skid enabled → FULL, `in_ready`=0.
  - Release → add issues, then sub, in order, none lost.
- Flush in FULL with `in_valid`=1 → next cycle `out_valid`=0, input not accepted.

Source files
------------

// File: rtl/alu_issue_32.sv
// alu_issue_32 - registered issue stage in front of alu_32.
//
// Takes a MIPS instruction word and its rs/rt operand values over a
// valid/ready handshake. It decodes opcode/funct into the ALU control code,
// the shift amount, operand B and the writeback/trap side-band bits. The
// result is then presented to the execute side over a second valid/ready
// handshake.
//
// Build option: define ALU_ISSUE_SKID_EN to add a skid entry (S) behind the
// main output register (M). In_ready is then registered and equals "S empty".
// Without it, in_ready = !out_valid | out_ready (combinational), and only
// M exists.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   flush                synchronous discard of all buffered entries
//   in_valid/in_ready    upstream handshake
//   in_instr             instruction word
//   in_rs_val/in_rt_val  register operand values
//   out_valid/out_ready  execute-side handshake
//   out_a, out_b         ALU operands
//   out_control          ALU control code
//   out_shamt            instr[10:6]
//   out_wr_en/out_wr_reg writeback enable / destination
//   out_ovf_trap         signed overflow must trap
//   out_illegal          instruction not decodable
//
// state | meaning
// EMPTY | M invalid
// ONE   | M valid, S empty
// FULL  | M and S valid (skid build only)

module alu_issue_32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_rs_val,
   input  logic [31:0] in_rt_val,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [3:0]  out_control,
   output logic [4:0]  out_shamt,
   output logic        out_wr_en,
   output logic [4:0]  out_wr_reg,
   output logic        out_ovf_trap,
   output logic        out_illegal
);

   localparam logic [3:0] CTRL_SLL  = 4'b0000;
   localparam logic [3:0] CTRL_SRL  = 4'b0010;
   localparam logic [3:0] CTRL_ADD  = 4'b1000;
   localparam logic [3:0] CTRL_SLT  = 4'b1001;
   localparam logic [3:0] CTRL_SUB  = 4'b1010;
   localparam logic [3:0] CTRL_SLTU = 4'b1011;
   localparam logic [3:0] CTRL_AND  = 4'b1100;
   localparam logic [3:0] CTRL_OR   = 4'b1101;
   localparam logic [3:0] CTRL_XOR  = 4'b1110;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  control;
      logic [4:0]  shamt;
      logic        wr_en;
      logic [4:0]  wr_reg;
      logic        ovf_trap;
      logic        illegal;
   } entry_t;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
   logic        unused_rs_field;

   assign opcode          = in_instr[31:26];
   assign rt              = in_instr[20:16];
   assign rd              = in_instr[15:11];
   assign funct           = in_instr[5:0];
   assign imm             = in_instr[15:0];
   assign imm_sext        = {{16{imm[15]}}, imm};
   assign imm_zext        = {16'h0000, imm};
   // rs selects the operand upstream; only its value is needed here.
   assign unused_rs_field = ^in_instr[25:21];

   entry_t dec;

   // Undecodable encodings fall through with R-type operand routing,
   // control=add, no writeback and no trap.
   always_comb begin
      dec          = '0;
      dec.a        = in_rs_val;
      dec.b        = in_rt_val;
      dec.shamt    = in_instr[10:6];
      dec.wr_reg   = rd;
      dec.control  = CTRL_ADD;
      dec.wr_en    = 1'b0;
      dec.ovf_trap = 1'b0;
      dec.illegal  = 1'b1;
      if (opcode == 6'h00) begin
         dec.illegal = 1'b0;
         dec.wr_en   = 1'b1;
         case (funct)
            6'h00:   dec.control = CTRL_SLL;
            6'h02:   dec.control = CTRL_SRL;
            6'h20: begin
               dec.control  = CTRL_ADD;
               dec.ovf_trap = 1'b1;
            end
            6'h21:   dec.control = CTRL_ADD;
            6'h22: begin
               dec.control  = CTRL_SUB;
               dec.ovf_trap = 1'b1;
            end
            6'h23:   dec.control = CTRL_SUB;
            6'h24:   dec.control = CTRL_AND;
            6'h25:   dec.control = CTRL_OR;
            6'h26:   dec.control = CTRL_XOR;
            6'h2A:   dec.control = CTRL_SLT;
            6'h2B:   dec.control = CTRL_SLTU;
            default: begin
               dec.illegal = 1'b1;
               dec.wr_en   = 1'b0;
            end
         endcase
      end else begin
         case (opcode)
            6'h08, 6'h09, 6'h23, 6'h2B: begin
               dec.illegal  = 1'b0;
               dec.control  = CTRL_ADD;
               dec.b        = imm_sext;
               dec.wr_reg   = rt;
               dec.wr_en    = (opcode != 6'h2B);
               dec.ovf_trap = (opcode == 6'h08);
            end
            6'h0A, 6'h0B: begin
               dec.illegal = 1'b0;
               dec.control = (opcode == 6'h0A) ? CTRL_SLT : CTRL_SLTU;
               dec.b       = imm_sext;
               dec.wr_reg  = rt;
               dec.wr_en   = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
               dec.illegal = 1'b0;
               dec.control = (opcode == 6'h0C) ? CTRL_AND :
                             (opcode == 6'h0D) ? CTRL_OR  : CTRL_XOR;
               dec.b       = imm_zext;
               dec.wr_reg  = rt;
               dec.wr_en   = 1'b1;
            end
            6'h04, 6'h05: begin
               dec.illegal = 1'b0;
               dec.control = CTRL_SUB;
               dec.wr_reg  = rt;
               dec.wr_en   = 1'b0;
            end
            default: ;
         endcase
      end
   end

   entry_t m_q;
   logic   out_valid_q;
   logic   accept;

`ifdef ALU_ISSUE_SKID_EN
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

   state_e state_q;
   entry_t s_q;
   logic   in_ready_q;

   assign in_ready = in_ready_q;
   assign accept   = in_valid & in_ready_q;

   // in_ready_q tracks "S empty" one cycle ahead, so it never looks at
   // out_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         m_q         <= '0;
         s_q         <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else if (flush) begin
         state_q     <= EMPTY;
         m_q         <= '0;
         s_q         <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  m_q         <= dec;
                  out_valid_q <= 1'b1;
                  state_q     <= ONE;
               end
            end
            ONE: begin
               if (accept && out_ready) begin
                  m_q <= dec;
               end else if (accept) begin
                  s_q        <= dec;
                  in_ready_q <= 1'b0;
                  state_q    <= FULL;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= EMPTY;
               end
            end
            FULL: begin
               if (out_ready) begin
                  m_q        <= s_q;
                  in_ready_q <= 1'b1;
                  state_q    <= ONE;
               end
            end
            default: begin
               state_q     <= EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end
`else
   typedef enum logic {EMPTY, ONE} state_e;

   state_e state_q;

   assign in_ready = !out_valid_q | out_ready;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         m_q         <= '0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         state_q     <= EMPTY;
         m_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  m_q         <= dec;
                  out_valid_q <= 1'b1;
                  state_q     <= ONE;
               end
            end
            ONE: begin
               // accept in ONE implies out_ready, so M is simply replaced.
               if (accept) begin
                  m_q <= dec;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= EMPTY;
               end
            end
         endcase
      end
   end
`endif

   assign out_valid    = out_valid_q;
   assign out_a        = m_q.a;
   assign out_b        = m_q.b;
   assign out_control  = m_q.control;
   assign out_shamt    = m_q.shamt;
   assign out_wr_en    = m_q.wr_en;
   assign out_wr_reg   = m_q.wr_reg;
   assign out_ovf_trap = m_q.ovf_trap;
   assign out_illegal  = m_q.illegal;

endmodule
